// File: rtl/keys_pkg.sv
// keys_pkg: shared constants for the key_input_pio peripheral.
//   - Avalon word offsets of the four registers
//   - COUNT register width
//   - default debounce interval (10 ms at 50 MHz)
//   - popcount16: number of set bits, used to advance COUNT by the
//     number of keys pressed in one cycle
package keys_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    localparam int COUNT_W          = 16;
    localparam int DEBOUNCE_DEFAULT = 500000;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one pushbutton bit.
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   key_n_i   raw active-low button, asynchronous to clk_i
//   stable_o  debounced key state (1 = pressed)
//   press_o   one-cycle pulse, high in the cycle before stable_o rises
//             (so the press is registered on the same edge as stable_o)
module key_debounce
    import keys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic stable_o,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q, sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized input disagrees with
    // the accepted state; any agreement (bounce back) restarts it at 0.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_o  = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
                press_o  = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= ~key_n_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/key_input_pio.sv
// key_input_pio: debounced pushbutton PIO on Avalon-MM.
//   clk, reset_n      system clock, asynchronous active-low reset
//   keys_n[WIDTH]     raw active-low pushbuttons
//   avs_address[2]    0 DATA (ro), 1 MASK (rw), 2 EDGE (w1c), 3 COUNT (write clears)
//   avs_read/avs_write, avs_writedata[32]
//   avs_readdata[32]  registered, valid the cycle after avs_read, held otherwise
//   irq               registered |(EDGE & MASK)
// WIDTH is 1..16, DEBOUNCE_CYCLES >= 2.
module key_input_pio
    import keys_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] keys_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    logic [WIDTH-1:0]   stable, press;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   edge_q, edge_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               irq_q;
    logic [15:0]        press16;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb [WIDTH-1:0] (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .key_n_i (keys_n),
        .stable_o(stable),
        .press_o (press)
    );

    // Register updates. Bus side effects are applied first, then the
    // press events on top, so a simultaneous press wins over a W1C and
    // a COUNT clear still counts this cycle's presses.
    always_comb begin
        mask_d  = mask_q;
        edge_d  = edge_q;
        count_d = count_q;
        press16 = '0;
        press16[WIDTH-1:0] = press;
        if (avs_write) begin
            case (avs_address)
                ADDR_MASK:  mask_d  = avs_writedata[WIDTH-1:0];
                ADDR_EDGE:  edge_d  = edge_q & ~avs_writedata[WIDTH-1:0];
                ADDR_COUNT: count_d = '0;
                default:    ;
            endcase
        end
        edge_d  = edge_d | press;
        count_d = count_d + COUNT_W'(popcount16(press16));
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                ADDR_DATA:  rdata_d = 32'(stable);
                ADDR_MASK:  rdata_d = 32'(mask_q);
                ADDR_EDGE:  rdata_d = 32'(edge_q);
                default:    rdata_d = 32'(count_q);
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q  <= '0;
            edge_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            // Registered from the current register values, so irq follows
            // an EDGE/MASK change by one edge.
            irq_q   <= |(edge_q & mask_q);
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;

    // Write data above the implemented key bits is ignored.
    logic unused_wdata;
    assign unused_wdata = ^{1'b0, avs_writedata[31:WIDTH]};

endmodule

// File: tb/tb_key_input_pio.sv
module tb_key_input_pio;
    import keys_pkg::*;

    localparam int W  = 4;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  keys_n = '1;
    logic [1:0]    avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic          irq;

    always #5 clk = ~clk;

    key_input_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .keys_n       (keys_n),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .irq          (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All driving happens just after a falling edge; one call = one cycle.
    task automatic bus(input bit rd, input bit wr, input logic [1:0] a,
                       input logic [31:0] wd, input string name,
                       input logic [31:0] ed, input logic ei);
        exp_t e;
        avs_read      = rd;
        avs_write     = wr;
        avs_address   = a;
        avs_writedata = wd;
        if (rd) begin
            e.name = name; e.data = ed; e.irq = ei;
            sb.push_back(e);
        end
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string name,
                      input logic [31:0] ed, input logic ei);
        bus(1'b1, 1'b0, a, 32'h0, name, ed, ei);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        bus(1'b0, 1'b1, a, wd, "", 32'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: a read sampled on a rising edge presents data after that
    // edge; compare it (and irq) on the following falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (avs_read === 1'b1) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got %h expected none", avs_readdata);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_data"}, avs_readdata, e.data);
                    chk({e.name, "_irq"}, 32'(irq), 32'(e.irq));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        idle(1);
        rd(ADDR_DATA,  "idle_data",  32'h0, 1'b0);
        rd(ADDR_MASK,  "idle_mask",  32'h0, 1'b0);
        rd(ADDR_EDGE,  "idle_edge",  32'h0, 1'b0);
        rd(ADDR_COUNT, "idle_count", 32'h0, 1'b0);

        // Single press on bit 0: stable at edge 10, irq at edge 11
        wr(ADDR_MASK, 32'h1);
        keys_n = 4'hE;
        idle(9);
        rd(ADDR_DATA,  "p0_data_e10",  32'h0, 1'b0);
        rd(ADDR_DATA,  "p0_data_e11",  32'h1, 1'b1);
        rd(ADDR_EDGE,  "p0_edge",      32'h1, 1'b1);
        rd(ADDR_COUNT, "p0_count",     32'h1, 1'b1);
        // W1C: irq still high on the write edge, low one edge later
        bus(1'b1, 1'b1, ADDR_EDGE, 32'h1, "p0_w1c_edge", 32'h1, 1'b1);
        rd(ADDR_EDGE,  "p0_edge_clr",  32'h0, 1'b0);
        keys_n = 4'hF;
        idle(12);
        rd(ADDR_DATA,  "rel_data",     32'h0, 1'b0);
        rd(ADDR_EDGE,  "rel_edge",     32'h0, 1'b0);
        rd(ADDR_COUNT, "rel_count",    32'h1, 1'b0);

        // Bounce on bit 1 never settles long enough
        wr(ADDR_COUNT, 32'h1234);
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) keys_n[1] = ~keys_n[1];
            idle(1);
        end
        keys_n = 4'hF;
        idle(12);
        rd(ADDR_DATA,  "bnc_data",  32'h0, 1'b0);
        rd(ADDR_EDGE,  "bnc_edge",  32'h0, 1'b0);
        rd(ADDR_COUNT, "bnc_count", 32'h0, 1'b0);

        // Two keys in one cycle, MASK=0
        wr(ADDR_MASK, 32'h0);
        keys_n = 4'h3;
        idle(12);
        rd(ADDR_EDGE,  "dual_edge",  32'hC, 1'b0);
        rd(ADDR_DATA,  "dual_data",  32'hC, 1'b0);
        rd(ADDR_COUNT, "dual_count", 32'h2, 1'b0);
        keys_n = 4'hF;
        idle(12);
        // Upper MASK bits read 0; irq rises one edge after the MASK write
        wr(ADDR_MASK, 32'hFFFF_FFF8);
        rd(ADDR_MASK,  "mask_rb",    32'h8, 1'b1);
        wr(ADDR_EDGE, 32'hC);
        rd(ADDR_EDGE,  "dual_clr",   32'h0, 1'b0);
        wr(ADDR_MASK, 32'h0);
        wr(ADDR_DATA, 32'hFFFF);
        rd(ADDR_DATA,  "data_ro",    32'h0, 1'b0);

        // Press coinciding with W1C of the same bit: set wins
        keys_n = 4'hE;
        idle(9);
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE,  "w1c_race_edge",  32'h1, 1'b0);
        rd(ADDR_COUNT, "w1c_race_count", 32'h3, 1'b0);
        keys_n = 4'hF;
        idle(12);

        // Two presses coinciding with a COUNT clear
        keys_n = 4'h3;
        idle(9);
        wr(ADDR_COUNT, 32'h0);
        rd(ADDR_COUNT, "clr_race_count", 32'h2, 1'b0);
        rd(ADDR_EDGE,  "clr_race_edge",  32'hD, 1'b0);
        keys_n = 4'hF;
        idle(12);

        // COUNT wrap from 0xFFFF
        force dut.count_q = 16'hFFFF;
        idle(1);
        release dut.count_q;
        rd(ADDR_COUNT, "wrap_pre", 32'hFFFF, 1'b0);
        keys_n = 4'hD;
        idle(12);
        rd(ADDR_COUNT, "wrap_post", 32'h0, 1'b0);
        rd(ADDR_EDGE,  "wrap_edge", 32'hF, 1'b0);
        keys_n = 4'hF;
        idle(12);

        // Reset mid-debounce (counter = 5) with key held
        wr(ADDR_MASK, 32'h1);
        keys_n = 4'hE;
        idle(7);
        reset_n = 1'b0;
        idle(1);
        chk("mid_rst_readdata", avs_readdata, 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        idle(9);
        rd(ADDR_DATA,  "rst_hold_e10",   32'h0, 1'b0);
        rd(ADDR_DATA,  "rst_hold_e11",   32'h1, 1'b0);
        rd(ADDR_EDGE,  "rst_hold_edge",  32'h1, 1'b0);
        rd(ADDR_COUNT, "rst_hold_count", 32'h1, 1'b0);
        rd(ADDR_MASK,  "rst_hold_mask",  32'h0, 1'b0);
        keys_n = 4'hF;

        idle(3);
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
